// File: rtl/wb_stage.sv
// Write-back stage: selects and formats the retiring result, waits for late load
// data, and drives the registered register-file write port plus retire/error status.
module wb_stage #(
   parameter int TIMEOUT = 15
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [4:0]  rd,
   input  logic        reg_write,
   input  logic [1:0]  mem_to_reg,
   input  logic [2:0]  funct3,
   input  logic [1:0]  addr_lo,
   input  logic [31:0] alu_result,
   input  logic [31:0] pc4,
   input  logic [31:0] imm,
   input  logic [31:0] dmem_rdata,
   input  logic        dmem_rvalid,
   output logic        rf_wr_n,
   output logic [4:0]  rf_wr_addr,
   output logic [31:0] rf_wr_data,
   output logic [31:0] instret,
   output logic        load_err,
   output logic        misalign_err
);

   typedef enum logic [0:0] {
      IDLE      = 1'b0,
      WAIT_LOAD = 1'b1
   } state_t;

   localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

   state_t      state_r;
   state_t      state_nxt_s;
   logic [7:0]  wait_cnt_r;
   logic [7:0]  wait_cnt_nxt_s;
   logic [7:0]  wait_cnt_inc_s;
   logic [4:0]  rd_r;
   logic        reg_write_r;
   logic [2:0]  funct3_r;
   logic [1:0]  addr_lo_r;
   logic        capture_s;
   logic        retire_s;
   logic        write_s;
   logic [4:0]  wr_addr_s;
   logic [31:0] wr_data_s;
   logic        set_misalign_s;
   logic        set_load_err_s;

   // Widths the load unit cannot serve: unaligned halves/words and reserved funct3.
   function automatic logic load_misaligned(input logic [2:0] f3, input logic [1:0] lane);
      logic bad;
      case (f3)
         3'b000, 3'b100: bad = 1'b0;
         3'b001, 3'b101: bad = lane[0];
         3'b010:         bad = (lane != 2'b00);
         default:        bad = 1'b1;
      endcase
      return bad;
   endfunction

   function automatic logic [31:0] load_format(input logic [2:0] f3, input logic [1:0] lane,
                                               input logic [31:0] word);
      logic [7:0]  byte_v;
      logic [15:0] half_v;
      logic [31:0] res;
      case (lane)
         2'b00:   byte_v = word[7:0];
         2'b01:   byte_v = word[15:8];
         2'b10:   byte_v = word[23:16];
         2'b11:   byte_v = word[31:24];
         default: byte_v = word[7:0];
      endcase
      half_v = lane[1] ? word[31:16] : word[15:0];
      case (f3)
         3'b000:  res = {{24{byte_v[7]}}, byte_v};
         3'b100:  res = {24'd0, byte_v};
         3'b001:  res = {{16{half_v[15]}}, half_v};
         3'b101:  res = {16'd0, half_v};
         default: res = word;
      endcase
      return res;
   endfunction

   assign in_ready       = (state_r == IDLE);
   assign wait_cnt_inc_s = wait_cnt_r + 8'd1;

   // Next-state, write-slot and error decisions for the current cycle.
   always_comb begin
      state_nxt_s    = state_r;
      wait_cnt_nxt_s = wait_cnt_r;
      capture_s      = 1'b0;
      retire_s       = 1'b0;
      write_s        = 1'b0;
      wr_addr_s      = rd;
      wr_data_s      = alu_result;
      set_misalign_s = 1'b0;
      set_load_err_s = 1'b0;
      case (state_r)
         IDLE: begin
            if (in_valid) begin
               if (mem_to_reg == 2'b01) begin
                  if (dmem_rvalid) begin
                     retire_s  = 1'b1;
                     wr_data_s = load_format(funct3, addr_lo, dmem_rdata);
                     if (load_misaligned(funct3, addr_lo)) begin
                        set_misalign_s = 1'b1;
                     end else begin
                        write_s = reg_write & (rd != 5'd0);
                     end
                  end else begin
                     state_nxt_s    = WAIT_LOAD;
                     wait_cnt_nxt_s = 8'd0;
                     capture_s      = 1'b1;
                  end
               end else begin
                  retire_s = 1'b1;
                  write_s  = reg_write & (rd != 5'd0);
                  case (mem_to_reg)
                     2'b10:   wr_data_s = pc4;
                     2'b11:   wr_data_s = imm;
                     default: wr_data_s = alu_result;
                  endcase
               end
            end else begin
               state_nxt_s = IDLE;
            end
         end
         WAIT_LOAD: begin
            wr_addr_s = rd_r;
            wr_data_s = load_format(funct3_r, addr_lo_r, dmem_rdata);
            // A response on the timeout edge still completes the load.
            if (dmem_rvalid) begin
               retire_s    = 1'b1;
               state_nxt_s = IDLE;
               if (load_misaligned(funct3_r, addr_lo_r)) begin
                  set_misalign_s = 1'b1;
               end else begin
                  write_s = reg_write_r & (rd_r != 5'd0);
               end
            end else if (wait_cnt_inc_s == TIMEOUT_C) begin
               set_load_err_s = 1'b1;
               wait_cnt_nxt_s = wait_cnt_inc_s;
               state_nxt_s    = IDLE;
            end else begin
               wait_cnt_nxt_s = wait_cnt_inc_s;
            end
         end
         default: begin
            state_nxt_s = IDLE;
         end
      endcase
   end

   // State, captured load context, register-file port and status registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r      <= IDLE;
         wait_cnt_r   <= 8'd0;
         rd_r         <= 5'd0;
         reg_write_r  <= 1'b0;
         funct3_r     <= 3'd0;
         addr_lo_r    <= 2'd0;
         rf_wr_n      <= 1'b1;
         rf_wr_addr   <= 5'd0;
         rf_wr_data   <= 32'd0;
         instret      <= 32'd0;
         load_err     <= 1'b0;
         misalign_err <= 1'b0;
      end else begin
         state_r    <= state_nxt_s;
         wait_cnt_r <= wait_cnt_nxt_s;
         if (capture_s) begin
            rd_r        <= rd;
            reg_write_r <= reg_write;
            funct3_r    <= funct3;
            addr_lo_r   <= addr_lo;
         end
         rf_wr_n <= ~write_s;
         if (write_s) begin
            rf_wr_addr <= wr_addr_s;
            rf_wr_data <= wr_data_s;
         end
         if (retire_s) begin
            instret <= instret + 32'd1;
         end
         load_err     <= load_err | set_load_err_s;
         misalign_err <= misalign_err | set_misalign_s;
      end
   end

endmodule

// File: tb/tb_wb_stage.sv
// Scoreboard bench for wb_stage: a transaction-level model predicts each write,
// retire and error flag; a negedge monitor checks the DUT every cycle.
module tb_wb_stage;

   localparam int TIMEOUT = 15;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [4:0]  rd = 5'd0;
   logic        reg_write = 1'b0;
   logic [1:0]  mem_to_reg = 2'd0;
   logic [2:0]  funct3 = 3'd0;
   logic [1:0]  addr_lo = 2'd0;
   logic [31:0] alu_result = 32'd0;
   logic [31:0] pc4 = 32'd0;
   logic [31:0] imm = 32'd0;
   logic [31:0] dmem_rdata = 32'd0;
   logic        dmem_rvalid = 1'b0;
   logic        rf_wr_n;
   logic [4:0]  rf_wr_addr;
   logic [31:0] rf_wr_data;
   logic [31:0] instret;
   logic        load_err;
   logic        misalign_err;

   wb_stage #(.TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .rd(rd), .reg_write(reg_write), .mem_to_reg(mem_to_reg), .funct3(funct3),
      .addr_lo(addr_lo), .alu_result(alu_result), .pc4(pc4), .imm(imm),
      .dmem_rdata(dmem_rdata), .dmem_rvalid(dmem_rvalid), .rf_wr_n(rf_wr_n),
      .rf_wr_addr(rf_wr_addr), .rf_wr_data(rf_wr_data), .instret(instret),
      .load_err(load_err), .misalign_err(misalign_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          neg;
      logic [4:0]  addr;
      logic [31:0] data;
   } wr_t;

   wr_t         exp_q[$];
   int          n_cmp = 0;
   int          n_fail = 0;
   int          neg_cnt = 0;
   bit          mon_on = 1'b0;
   logic [31:0] m_instret = 32'd0;
   logic        m_load_err = 1'b0;
   logic        m_mis_err = 1'b0;
   logic [4:0]  m_addr = 5'd0;
   logic [31:0] m_data = 32'd0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference load semantics: pick the lane by shifting, extend by signed casts.
   function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [1:0] lane,
                                            input logic [31:0] w, output bit bad);
      logic [31:0]        sh;
      logic [31:0]        shh;
      logic signed [7:0]  b;
      logic signed [15:0] h;
      logic [31:0]        res;
      int                 il;
      il  = int'(lane);
      sh  = w >> (8 * il);
      shh = w >> (16 * (il / 2));
      b   = sh[7:0];
      h   = shh[15:0];
      bad = 1'b0;
      res = 32'd0;
      case (f3)
         3'd0: res = 32'(int'(b));
         3'd4: res = {24'd0, sh[7:0]};
         3'd1: begin bad = (il % 2) != 0; res = 32'(int'(h)); end
         3'd5: begin bad = (il % 2) != 0; res = {16'd0, shh[15:0]}; end
         3'd2: begin bad = (il != 0); res = w; end
         default: bad = 1'b1;
      endcase
      return res;
   endfunction

   // Monitor: every falling edge compare the whole write port and status to the model.
   initial begin
      bit due;
      forever begin
         @(negedge clk);
         neg_cnt = neg_cnt + 1;
         if (mon_on) begin
            due = (exp_q.size() > 0) && (exp_q[0].neg == neg_cnt);
            check("rf_wr_n", 32'(rf_wr_n), due ? 32'd0 : 32'd1);
            if (due) begin
               m_addr = exp_q[0].addr;
               m_data = exp_q[0].data;
               void'(exp_q.pop_front());
            end
            check("rf_wr_addr", 32'(rf_wr_addr), 32'(m_addr));
            check("rf_wr_data", rf_wr_data, m_data);
            check("instret", instret, m_instret);
            check("load_err", 32'(load_err), 32'(m_load_err));
            check("misalign_err", 32'(misalign_err), 32'(m_mis_err));
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic model_retire(input logic [4:0] r, input logic rw, input logic [31:0] d);
      m_instret = m_instret + 32'd1;
      if (rw && r != 5'd0) exp_q.push_back('{neg_cnt + 1, r, d});
   endtask

   // k = edge (after the accept edge) on which the load response arrives; 0 = same edge.
   task automatic issue(input logic [4:0] i_rd, input logic i_rw, input logic [1:0] i_m2r,
                        input logic [2:0] i_f3, input logic [1:0] i_alo,
                        input logic [31:0] i_word, input int k);
      logic [31:0] res;
      bit          bad;
      int          lim;
      check("in_ready_idle", 32'(in_ready), 32'd1);
      in_valid   = 1'b1;
      rd         = i_rd;
      reg_write  = i_rw;
      mem_to_reg = i_m2r;
      funct3     = i_f3;
      addr_lo    = i_alo;
      alu_result = (i_m2r == 2'd0) ? i_word : $urandom;
      pc4        = (i_m2r == 2'd2) ? i_word : $urandom;
      imm        = (i_m2r == 2'd3) ? i_word : $urandom;
      dmem_rdata = (i_m2r == 2'd1 && k == 0) ? i_word : $urandom;
      dmem_rvalid = (i_m2r == 2'd1) ? (k == 0) : 1'($urandom % 2);
      step();
      if (i_m2r != 2'd1 || k == 0) begin
         if (i_m2r == 2'd1) begin
            res = ref_load(i_f3, i_alo, i_word, bad);
            if (bad) begin
               m_instret = m_instret + 32'd1;
               m_mis_err = 1'b1;
            end else begin
               model_retire(i_rd, i_rw, res);
            end
         end else begin
            model_retire(i_rd, i_rw, i_word);
         end
      end else begin
         lim = (k > TIMEOUT) ? TIMEOUT : k;
         for (int i = 1; i <= lim; i++) begin
            check("in_ready_wait", 32'(in_ready), 32'd0);
            in_valid    = 1'($urandom % 2);
            rd          = 5'($urandom);
            reg_write   = 1'($urandom);
            mem_to_reg  = 2'($urandom);
            funct3      = 3'($urandom);
            addr_lo     = 2'($urandom);
            dmem_rvalid = (i == k);
            dmem_rdata  = (i == k) ? i_word : $urandom;
            step();
         end
         if (k > TIMEOUT) begin
            m_load_err = 1'b1;
         end else begin
            res = ref_load(i_f3, i_alo, i_word, bad);
            if (bad) begin
               m_instret = m_instret + 32'd1;
               m_mis_err = 1'b1;
            end else begin
               model_retire(i_rd, i_rw, res);
            end
         end
      end
      in_valid    = 1'b0;
      dmem_rvalid = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         in_valid    = 1'b0;
         dmem_rvalid = 1'($urandom % 2);
         dmem_rdata  = $urandom;
         step();
      end
      dmem_rvalid = 1'b0;
   endtask

   task automatic model_reset();
      exp_q.delete();
      m_instret  = 32'd0;
      m_load_err = 1'b0;
      m_mis_err  = 1'b0;
      m_addr     = 5'd0;
      m_data     = 32'd0;
   endtask

   task automatic do_reset();
      reset       = 1'b1;
      in_valid    = 1'b0;
      dmem_rvalid = 1'b0;
      model_reset();
      step();
      step();
      reset = 1'b0;
   endtask

   initial begin
      int          r;
      int          k;
      logic [1:0]  m2r;
      logic [2:0]  f3;
      logic [2:0]  legal_f3 [5];
      legal_f3[0] = 3'd0; legal_f3[1] = 3'd1; legal_f3[2] = 3'd2;
      legal_f3[3] = 3'd4; legal_f3[4] = 3'd5;

      step();
      mon_on = 1'b1;
      step();
      reset = 1'b0;

      // Directed cases
      issue(5'd5, 1'b1, 2'd0, 3'd0, 2'd0, 32'h0000_1234, 0);
      idle(2);
      issue(5'd7, 1'b1, 2'd1, 3'd0, 2'd3, 32'h80FF_FFFF, 5);
      check("in_ready_after_load", 32'(in_ready), 32'd1);
      issue(5'd8, 1'b1, 2'd1, 3'd5, 2'd2, 32'h9ABC_0000, 0);
      issue(5'd9, 1'b1, 2'd1, 3'd1, 2'd2, 32'h9ABC_0000, 2);
      issue(5'd0, 1'b1, 2'd2, 3'd0, 2'd0, 32'h0000_0104, 0);
      issue(5'd3, 1'b0, 2'd3, 3'd0, 2'd0, 32'hDEAD_B000, 0);
      issue(5'd10, 1'b1, 2'd1, 3'd2, 2'd1, 32'h1111_2222, 0);
      issue(5'd11, 1'b1, 2'd1, 3'd3, 2'd0, 32'h3333_4444, 3);
      idle(1);
      do_reset();
      issue(5'd12, 1'b1, 2'd1, 3'd2, 2'd0, 32'hCAFE_F00D, TIMEOUT);
      issue(5'd13, 1'b1, 2'd1, 3'd4, 2'd1, 32'h0000_AB00, TIMEOUT + 1);
      check("in_ready_after_timeout", 32'(in_ready), 32'd1);
      issue(5'd14, 1'b1, 2'd0, 3'd0, 2'd0, 32'h0000_0042, 0);

      // Reset while a load is waiting; a late response must not write.
      in_valid = 1'b1; rd = 5'd15; reg_write = 1'b1; mem_to_reg = 2'd1;
      funct3 = 3'd2; addr_lo = 2'd0; dmem_rvalid = 1'b0;
      step();
      in_valid = 1'b0;
      step();
      check("in_ready_wait_pre_reset", 32'(in_ready), 32'd0);
      do_reset();
      dmem_rvalid = 1'b1;
      dmem_rdata  = 32'h5555_AAAA;
      step();
      step();
      dmem_rvalid = 1'b0;
      issue(5'd1, 1'b1, 2'd0, 3'd0, 2'd0, 32'h0000_0001, 0);
      issue(5'd2, 1'b1, 2'd0, 3'd0, 2'd0, 32'h0000_0002, 0);
      issue(5'd3, 1'b1, 2'd0, 3'd0, 2'd0, 32'h0000_0003, 0);
      idle(1);
      check("instret_three", instret, 32'd3);

      // Randomized traffic
      for (int n = 0; n < 400; n++) begin
         m2r = 2'($urandom);
         if ($urandom % 2 == 0) m2r = 2'd1;
         f3 = ($urandom % 10 < 8) ? legal_f3[$urandom % 5] : 3'($urandom);
         r = $urandom % 10;
         if (r < 5)       k = 0;
         else if (r < 8)  k = 1 + ($urandom % 4);
         else if (r == 8) k = TIMEOUT - ($urandom % 2);
         else             k = TIMEOUT + 1 + ($urandom % 3);
         issue(($urandom % 4 == 0) ? 5'd0 : 5'($urandom), 1'($urandom % 8 != 0), m2r, f3,
               2'($urandom), $urandom, k);
         if ($urandom % 4 == 0) idle(1 + ($urandom % 3));
         if ($urandom % 100 == 0) begin
            idle(1);
            do_reset();
         end
      end
      idle(3);
      check("queue_drained", 32'(exp_q.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
Write-back stage of the 32I pipeline. It is the writer on the register-file write port that the decode stage reads from. It accepts one retiring instruction per handshake and selects the result source (ALU, load data, PC+4, or immediate). It aligns and extends load data, waits for late load responses, and drives the registered write strobe, address and data into rf32x32. It also maintains a retired-instruction counter and sticky error flags.

Parameters:
TIMEOUT, 15, max cycles spent in WAIT_LOAD before abort (1..255)

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-high
in_valid  input  1  retiring instruction presented
in_ready  output  1  stage can accept; combinational, =1 only in IDLE
rd  input  5  destination register
reg_write  input  1  instruction writes rd (active high)
mem_to_reg  input  2  source select: 00 ALU, 01 load, 10 PC+4, 11 immediate
funct3  input  3  load width/sign
addr_lo  input  2  byte address bits [1:0] of the load
alu_result  input  32  ALU output
pc4  input  32  PC+4 (jal/jalr link)
imm  input  32  sign-extended immediate (lui)
dmem_rdata  input  32  data-memory read word
dmem_rvalid  input  1  dmem_rdata valid this cycle
rf_wr_n  output  1  register-file write strobe, active low, registered
rf_wr_addr  output  5  registered write address
rf_wr_data  output  32  registered write data
instret  output  32  retired-instruction count, wraps at 2^32
load_err  output  1  sticky: load timeout
misalign_err  output  1  sticky: misaligned or illegal load

Behaviour:
- Reset (async): state IDLE, rf_wr_n=1, rf_wr_addr=0, rf_wr_data=0, instret=0, load_err=0, misalign_err=0, wait counter=0.
- Acceptance: an instruction is accepted when in_valid && in_ready at a rising edge. All inputs are sampled at that edge. Loads waiting in WAIT_LOAD hold a captured copy of rd, reg_write, funct3 and addr_lo.
- IDLE, non-load accept (mem_to_reg != 01):
  - Write occurs in the next cycle: rf_wr_n=0 for exactly one cycle, with addr=rd and data=selected source.
  - Remain in IDLE. Back-to-back accepts give back-to-back write cycles.
- IDLE, load accept with dmem_rvalid=1 in the same cycle: behave as a non-load accept (1-cycle latency).
- IDLE, load accept with dmem_rvalid=0: go to WAIT_LOAD, clear the wait counter; in_ready=0.
- WAIT_LOAD:
  - On dmem_rvalid=1: write the formatted data in the next cycle, then return to IDLE.
  - Otherwise increment the wait counter. If the counter reaches TIMEOUT: set load_err, perform no write, do not count the instruction, return to IDLE.
  - A response arriving on the same edge that the counter reaches TIMEOUT wins; no error is raised.
- Load formatting, using byte lane = addr_lo:
  - 000 lb: sign-extend the selected byte.
  - 100 lbu: zero-extend the selected byte.
  - 001 lh / 101 lhu: use the half-word at addr_lo[1]; sign- or zero-extend respectively.
  - 010 lw: the full word.
- Misalignment: lh/lhu with addr_lo[0]=1, lw with addr_lo!=0, or any other funct3 value:
  - Set misalign_err, perform no write, still count as retired.
  - Check on the response; dmem_rvalid is still awaited.
- rd==0 or reg_write=0: rf_wr_n stays 1, rf_wr_addr and rf_wr_data hold their previous values, and the instruction still retires.
- instret increments in the same cycle as the write slot (or the suppressed-write slot) of every retired instruction; it wraps from 0xFFFFFFFF to 0.
- Reset mid-WAIT_LOAD: the pending load is dropped and the state returns to IDLE immediately. A dmem_rvalid arriving after reset is ignored.
- A dmem_rvalid in IDLE with no load being accepted is ignored.

Test Plan:
- ALU write: accept rd=5, mem_to_reg=00, alu_result=0x1234 -> next cycle rf_wr_n=0, addr=5, data=0x1234; following cycle rf_wr_n=1; instret=1.
- Delayed lb: accept load funct3=000, addr_lo=3, dmem_rvalid low for 4 cycles, then dmem_rdata=0x80FF_FF_FF -> in_ready=0 for 5 cycles; write data=0xFFFFFF80; in_ready=1 again.
- lhu/lh: addr_lo=2, rdata=0x9ABC_0000 -> lhu writes 0x00009ABC, lh writes 0xFFFF9ABC.
- Suppression: rd=0 with jal (mem_to_reg=10) -> no rf_wr_n pulse, instret increments; lw with addr_lo=1 -> misalign_err=1, no write.
- Timeout: TIMEOUT=15, load with no response -> after 15 cycles load_err=1, no write, instret unchanged, in_ready=1; response on cycle 15 instead -> write, load_err=0.
- Reset mid-wait plus back-to-back: assert reset during WAIT_LOAD -> all outputs are at reset values, and a late dmem_rvalid causes no write. Then 3 consecutive ALU accepts -> 3 consecutive write cycles, instret=3.
